// File: rtl/bitwise_logic_seq_pkg.sv
// Opcode constants and FSM state encoding shared by bitwise_logic_seq and its slice datapath.
package bitwise_logic_seq_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bitwise_logic_seq_slice.sv
// One SLICE-bit chunk of the bitwise op; purely combinational.
// No state and no flow control; the parent sequences the chunks.
module bitwise_slice
  import bitwise_logic_seq_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [1:0]       op,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic [SLICE-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = ~(a | b);
    endcase
  end

endmodule

// File: rtl/bitwise_logic_seq.sv
// Slice-serial bitwise AND/OR/XOR/NOR. Result is valid WIDTH/SLICE cycles after acceptance.
// One request in flight; the result holds in DONE until out_ready, and in_ready is high only in IDLE.
module bitwise_logic_seq
  import bitwise_logic_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / SLICE;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_y;
  logic             r_zero;
  logic             r_out_valid;
  logic             r_in_ready;

  logic [SLICE-1:0] w_a_chunk;
  logic [SLICE-1:0] w_b_chunk;
  logic [SLICE-1:0] w_y_chunk;

  assign w_a_chunk = r_a[int'(r_cnt) * SLICE +: SLICE];
  assign w_b_chunk = r_b[int'(r_cnt) * SLICE +: SLICE];

  bitwise_slice #(.SLICE(SLICE)) u_slice (
    .op (r_op),
    .a  (w_a_chunk),
    .b  (w_b_chunk),
    .y  (w_y_chunk)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_y         <= '0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op       <= op;
            r_a        <= A;
            r_b        <= B;
            r_cnt      <= '0;
            // zero flag is an AND across chunks, so it starts out true
            r_zero     <= 1'b1;
            r_in_ready <= 1'b0;
            r_state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_y[int'(r_cnt) * SLICE +: SLICE] <= w_y_chunk;
          r_zero <= r_zero & (w_y_chunk == '0);
          if (r_cnt == LAST) begin
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign Y         = r_y;
  assign zero      = r_zero;

endmodule
